// File: rtl/add_checker.sv
// add_checker: streams (a, b, sum) beats from an adder under test through a
// two-stage compare pipeline and tallies pass/fail results for one run.
// The run length is num_vec beats, captured when start is accepted.
// Optional feature: define ADD_CHECKER_FAIL_CAPTURE_EN to add the
// first_fail_a / first_fail_b / first_fail_sum outputs.
module add_checker #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_vec,
    input  logic               chk_valid,
    output logic               chk_ready,
    input  logic [WIDTH-1:0]   chk_a,
    input  logic [WIDTH-1:0]   chk_b,
    input  logic [WIDTH-1:0]   chk_sum,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] pass_cnt,
    output logic [COUNT_W-1:0] fail_cnt,
    output logic               mismatch,
    output logic [COUNT_W-1:0] first_fail_idx
`ifdef ADD_CHECKER_FAIL_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]   first_fail_a,
    output logic [WIDTH-1:0]   first_fail_b,
    output logic [WIDTH-1:0]   first_fail_sum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_start_ok;
    logic                 w_room;
    logic                 w_accept;
    logic                 w_last_beat;
    logic [COUNT_W:0]     w_beat_nxt;
    logic [WIDTH-1:0]     w_expected;

    logic [COUNT_W-1:0]   r_num_vec;
    logic [COUNT_W-1:0]   r_beat_idx;

    logic                 r_s1_valid;
    logic [WIDTH-1:0]     r_s1_a;
    logic [WIDTH-1:0]     r_s1_b;
    logic [WIDTH-1:0]     r_s1_sum;
    logic [COUNT_W-1:0]   r_s1_idx;

    logic                 r_s2_valid;
    logic                 r_s2_match;
    logic [COUNT_W-1:0]   r_s2_idx;

    logic [COUNT_W-1:0]   r_pass_cnt;
    logic [COUNT_W-1:0]   r_fail_cnt;
    logic                 r_mismatch;
    logic [COUNT_W-1:0]   r_first_fail_idx;

    assign w_room      = (r_beat_idx < r_num_vec);
    assign w_accept    = chk_valid && chk_ready;
    assign w_beat_nxt  = {1'b0, r_beat_idx} + {{COUNT_W{1'b0}}, 1'b1};
    assign w_last_beat = (w_beat_nxt == {1'b0, r_num_vec});
    assign w_expected  = r_s1_a + r_s1_b;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and status outputs; DRAIN leaves on the edge that retires
    // the final stage-2 entry so done rises together with the last count.
    always_comb begin
        w_state_nxt = r_state;
        chk_ready   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        w_start_ok  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done       = (r_state == S_DONE);
                w_start_ok = start;
                if (start) w_state_nxt = (num_vec == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                busy      = 1'b1;
                chk_ready = w_room;
                if (chk_valid && w_room && w_last_beat) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!r_s1_valid) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Run length capture and accepted-beat index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_num_vec  <= '0;
            r_beat_idx <= '0;
        end else if (w_start_ok) begin
            r_num_vec  <= num_vec;
            r_beat_idx <= '0;
        end else if (w_accept) begin
            r_beat_idx <= w_beat_nxt[COUNT_W-1:0];
        end
    end

    // Stage 1: register the accepted beat and its index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_sum   <= '0;
            r_s1_idx   <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a   <= chk_a;
                r_s1_b   <= chk_b;
                r_s1_sum <= chk_sum;
                r_s1_idx <= r_beat_idx;
            end
        end
    end

    // Stage 2: compare observed sum against the carry-discarded expected sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_match <= 1'b0;
            r_s2_idx   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_match <= (w_expected == r_s1_sum);
                r_s2_idx   <= r_s1_idx;
            end
        end
    end

    // Result counters (saturating) and first-failure record
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass_cnt       <= '0;
            r_fail_cnt       <= '0;
            r_mismatch       <= 1'b0;
            r_first_fail_idx <= '0;
        end else if (w_start_ok) begin
            r_pass_cnt       <= '0;
            r_fail_cnt       <= '0;
            r_mismatch       <= 1'b0;
            r_first_fail_idx <= '0;
        end else if (r_s2_valid) begin
            if (r_s2_match) begin
                if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + CNT_ONE;
            end else begin
                if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_ONE;
                if (!r_mismatch) begin
                    r_mismatch       <= 1'b1;
                    r_first_fail_idx <= r_s2_idx;
                end
            end
        end
    end

    assign pass_cnt       = r_pass_cnt;
    assign fail_cnt       = r_fail_cnt;
    assign mismatch       = r_mismatch;
    assign first_fail_idx = r_first_fail_idx;

`ifdef ADD_CHECKER_FAIL_CAPTURE_EN
    logic [WIDTH-1:0] r_s2_a;
    logic [WIDTH-1:0] r_s2_b;
    logic [WIDTH-1:0] r_s2_sum;
    logic [WIDTH-1:0] r_ff_a;
    logic [WIDTH-1:0] r_ff_b;
    logic [WIDTH-1:0] r_ff_sum;

    // Carry operands alongside the compare result, latch them on first failure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_a   <= '0;
            r_s2_b   <= '0;
            r_s2_sum <= '0;
            r_ff_a   <= '0;
            r_ff_b   <= '0;
            r_ff_sum <= '0;
        end else begin
            if (r_s1_valid) begin
                r_s2_a   <= r_s1_a;
                r_s2_b   <= r_s1_b;
                r_s2_sum <= r_s1_sum;
            end
            if (w_start_ok) begin
                r_ff_a   <= '0;
                r_ff_b   <= '0;
                r_ff_sum <= '0;
            end else if (r_s2_valid && !r_s2_match && !r_mismatch) begin
                r_ff_a   <= r_s2_a;
                r_ff_b   <= r_s2_b;
                r_ff_sum <= r_s2_sum;
            end
        end
    end

    assign first_fail_a   = r_ff_a;
    assign first_fail_b   = r_ff_b;
    assign first_fail_sum = r_ff_sum;
`else
    // Without capture, only the index and mismatch flag record the first failure.
`endif

endmodule

// File: tb/tb_add_checker.sv
// Testbench for add_checker: directed and randomized runs checked every cycle
// against a timeline model (a beat accepted at edge e is counted at edge e+2).
`timescale 1ns/1ps
module tb_add_checker;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned COUNT_W = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [COUNT_W-1:0] num_vec;
    logic               chk_valid;
    logic               chk_ready;
    logic [WIDTH-1:0]   chk_a;
    logic [WIDTH-1:0]   chk_b;
    logic [WIDTH-1:0]   chk_sum;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] pass_cnt;
    logic [COUNT_W-1:0] fail_cnt;
    logic               mismatch;
    logic [COUNT_W-1:0] first_fail_idx;
`ifdef ADD_CHECKER_FAIL_CAPTURE_EN
    logic [WIDTH-1:0]   first_fail_a;
    logic [WIDTH-1:0]   first_fail_b;
    logic [WIDTH-1:0]   first_fail_sum;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] va [64];
    logic [WIDTH-1:0] vb [64];
    logic [WIDTH-1:0] vs [64];

    always #5 clk = ~clk;

    add_checker #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .num_vec        (num_vec),
        .chk_valid      (chk_valid),
        .chk_ready      (chk_ready),
        .chk_a          (chk_a),
        .chk_b          (chk_b),
        .chk_sum        (chk_sum),
        .busy           (busy),
        .done           (done),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .mismatch       (mismatch),
        .first_fail_idx (first_fail_idx)
`ifdef ADD_CHECKER_FAIL_CAPTURE_EN
        ,
        .first_fail_a   (first_fail_a),
        .first_fail_b   (first_fail_b),
        .first_fail_sum (first_fail_sum)
`endif
    );

    // Reference rule: the sum is correct when it equals (a+b) modulo 2^WIDTH.
    function automatic bit beat_ok(input int i);
        longint unsigned full;
        longint unsigned modv;
        full = 64'(va[i]) + 64'(vb[i]);
        modv = 64'd1 << WIDTH;
        return (full % modv) == 64'(vs[i]);
    endfunction

    // Runs one job of n beats and checks every cycle until done is expected.
    task automatic run_job(input int n, input bit gaps, input bit hold);
        int  k;
        int  edge_no;
        int  limit;
        int  acc_edge[$];
        bit  acc;
        int  ep;
        int  ef;
        int  fidx;
        bit  exp_done;
        bit  exp_ready;
        logic [COUNT_W-1:0] exp_ffi;
        k = 0; edge_no = 0; limit = n * 10 + 20;
        chk_valid = 1'b0;
        start = 1'b1;
        num_vec = COUNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        forever begin
            ep = 0; ef = 0; fidx = -1;
            foreach (acc_edge[i]) begin
                if (acc_edge[i] + 2 <= edge_no) begin
                    if (beat_ok(i)) ep++;
                    else begin
                        ef++;
                        if (fidx < 0) fidx = i;
                    end
                end
            end
            exp_done = 1'b0;
            if (k == n) begin
                if (n == 0) exp_done = 1'b1;
                else if (acc_edge[n-1] + 2 <= edge_no) exp_done = 1'b1;
            end
            exp_ready = (k < n);
            exp_ffi   = (fidx < 0) ? '0 : COUNT_W'(fidx);

            n_cmp++;
            if (chk_ready !== exp_ready)
                $display("FAIL ready n=%0d cyc=%0d: got %b want %b", n, edge_no, chk_ready, exp_ready);
            if (chk_ready !== exp_ready) n_err++;
            n_cmp++;
            if (busy !== !exp_done) begin
                n_err++;
                $display("FAIL busy n=%0d cyc=%0d: got %b want %b", n, edge_no, busy, !exp_done);
            end
            n_cmp++;
            if (done !== exp_done) begin
                n_err++;
                $display("FAIL done n=%0d cyc=%0d: got %b want %b", n, edge_no, done, exp_done);
            end
            n_cmp++;
            if (pass_cnt !== COUNT_W'(ep)) begin
                n_err++;
                $display("FAIL pass_cnt n=%0d cyc=%0d: got %0d want %0d", n, edge_no, pass_cnt, ep);
            end
            n_cmp++;
            if (fail_cnt !== COUNT_W'(ef)) begin
                n_err++;
                $display("FAIL fail_cnt n=%0d cyc=%0d: got %0d want %0d", n, edge_no, fail_cnt, ef);
            end
            n_cmp++;
            if (mismatch !== (ef > 0)) begin
                n_err++;
                $display("FAIL mismatch n=%0d cyc=%0d: got %b want %b", n, edge_no, mismatch, (ef > 0));
            end
            n_cmp++;
            if (first_fail_idx !== exp_ffi) begin
                n_err++;
                $display("FAIL first_fail_idx n=%0d cyc=%0d: got %0d want %0d", n, edge_no, first_fail_idx, exp_ffi);
            end
`ifdef ADD_CHECKER_FAIL_CAPTURE_EN
            n_cmp++;
            if ((fidx < 0 && {first_fail_a, first_fail_b, first_fail_sum} !== '0) ||
                (fidx >= 0 && {first_fail_a, first_fail_b, first_fail_sum} !== {va[fidx], vb[fidx], vs[fidx]})) begin
                n_err++;
                $display("FAIL capture n=%0d cyc=%0d: got %h/%h/%h fidx %0d", n, edge_no,
                         first_fail_a, first_fail_b, first_fail_sum, fidx);
            end
`endif
            if (exp_done) break;
            if (edge_no > limit) begin
                n_cmp++; n_err++;
                $display("FAIL timeout n=%0d: done not reached in %0d cycles", n, limit);
                break;
            end
            if (k < n) begin
                chk_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                chk_a = va[k]; chk_b = vb[k]; chk_sum = vs[k];
            end else begin
                chk_valid = hold ? 1'b1 : 1'(($urandom_range(0, 1)));
            end
            // start while busy must be ignored
            start   = gaps ? ($urandom_range(0, 7) == 0) : 1'b0;
            num_vec = COUNT_W'($urandom_range(0, 9));
            acc = chk_valid && exp_ready;
            @(posedge clk);
            edge_no++;
            if (acc) begin
                acc_edge.push_back(edge_no);
                k++;
            end
            #1;
        end
        start = 1'b0;
        chk_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            va[i] = ($urandom_range(0, 7) == 0) ? '1 : WIDTH'($urandom);
            vb[i] = WIDTH'($urandom);
            vs[i] = ($urandom_range(0, 1) == 1) ? va[i] + vb[i] : WIDTH'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; chk_valid = 1'b0; num_vec = '0;
        chk_a = '0; chk_b = '0; chk_sum = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({chk_ready, busy, done, mismatch} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got %b want 0000", {chk_ready, busy, done, mismatch});
        end
        n_cmp++;
        if ({pass_cnt, fail_cnt, first_fail_idx} !== '0) begin
            n_err++;
            $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", pass_cnt, fail_cnt, first_fail_idx);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_all_pass();
        va[0] = 32'h0; vb[0] = 32'h0; vs[0] = 32'h0;
        va[1] = 32'hA; vb[1] = 32'hC; vs[1] = 32'h16;
        va[2] = 32'hB; vb[2] = 32'h2; vs[2] = 32'hD;
        va[3] = 32'h4; vb[3] = 32'h1; vs[3] = 32'h5;
        run_job(4, 1'b0, 1'b0);
        n_cmp++;
        if (!(done === 1'b1 && pass_cnt === 16'd4 && fail_cnt === 16'd0 && mismatch === 1'b0)) begin
            n_err++;
            $display("FAIL all_pass: got done=%b p=%0d f=%0d m=%b want 1/4/0/0", done, pass_cnt, fail_cnt, mismatch);
        end
    endtask

    task automatic test_two_fail();
        vs[2] = 32'h6;
        vs[3] = 32'h9;
        run_job(4, 1'b0, 1'b0);
        n_cmp++;
        if (!(pass_cnt === 16'd2 && fail_cnt === 16'd2 && mismatch === 1'b1 && first_fail_idx === 16'd2)) begin
            n_err++;
            $display("FAIL two_fail: got p=%0d f=%0d m=%b idx=%0d want 2/2/1/2", pass_cnt, fail_cnt, mismatch, first_fail_idx);
        end
`ifdef ADD_CHECKER_FAIL_CAPTURE_EN
        n_cmp++;
        if (!(first_fail_a === 32'hB && first_fail_b === 32'h2 && first_fail_sum === 32'h6)) begin
            n_err++;
            $display("FAIL two_fail_capture: got %h/%h/%h want b/2/6", first_fail_a, first_fail_b, first_fail_sum);
        end
`endif
    endtask

    task automatic test_wrap();
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h1; vs[0] = 32'h0;
        run_job(1, 1'b0, 1'b0);
        n_cmp++;
        if (!(pass_cnt === 16'd1 && fail_cnt === 16'd0)) begin
            n_err++;
            $display("FAIL wrap: got p=%0d f=%0d want 1/0", pass_cnt, fail_cnt);
        end
    endtask

    task automatic test_hold_valid();
        fill_random(2);
        run_job(2, 1'b0, 1'b1);
        n_cmp++;
        if (32'(pass_cnt) + 32'(fail_cnt) !== 32'd2) begin
            n_err++;
            $display("FAIL hold_valid: got pass+fail=%0d want 2", 32'(pass_cnt) + 32'(fail_cnt));
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 24);
            fill_random(n);
            run_job(n, 1'b0, 1'b0);
        end
    endtask

    task automatic test_random_gaps();
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 40);
            fill_random(n);
            run_job(n, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_midrun();
        va[0] = 32'h1; vb[0] = 32'h1; vs[0] = 32'h7;
        va[1] = 32'h2; vb[1] = 32'h2; vs[1] = 32'h4;
        va[2] = 32'h3; vb[2] = 32'h3; vs[2] = 32'h6;
        va[3] = 32'h4; vb[3] = 32'h4; vs[3] = 32'h1;
        start = 1'b1; num_vec = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk_valid = 1'b1; chk_a = va[i]; chk_b = vb[i]; chk_sum = vs[i];
            @(posedge clk); #1;
        end
        chk_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({chk_ready, busy, done, mismatch, pass_cnt, fail_cnt, first_fail_idx} !== '0) begin
            n_err++;
            $display("FAIL midrun_async: got r=%b b=%b d=%b m=%b p=%0d f=%0d i=%0d want all 0",
                     chk_ready, busy, done, mismatch, pass_cnt, fail_cnt, first_fail_idx);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({chk_ready, busy, done, mismatch, pass_cnt, fail_cnt} !== '0) begin
                n_err++;
                $display("FAIL midrun_after cyc=%0d: got b=%b d=%b m=%b p=%0d f=%0d want all 0",
                         c, busy, done, mismatch, pass_cnt, fail_cnt);
            end
        end
        run_job(0, 1'b0, 1'b0);
        n_cmp++;
        if (!(done === 1'b1 && pass_cnt === 16'd0 && fail_cnt === 16'd0)) begin
            n_err++;
            $display("FAIL zero_run: got d=%b p=%0d f=%0d want 1/0/0", done, pass_cnt, fail_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_two_fail();
        test_wrap();
        test_hold_valid();
        test_back_to_back();
        test_random_gaps();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
